// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: glyph patterns ({g,f,e,d,c,b,a},
// active-high), digit count and the frame-assembly state encoding.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational seven-segment glyph to hex nibble decoder; unknown patterns give
// nibble 0 with valid_o low.
module seg7_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       valid_o
);

  // Pattern lookup: exactly sixteen legal glyphs, everything else is rejected
  always_comb begin
    nibble_o = 4'h0;
    valid_o  = 1'b1;
    case (pattern_i)
      GLYPH_0: nibble_o = 4'h0;
      GLYPH_1: nibble_o = 4'h1;
      GLYPH_2: nibble_o = 4'h2;
      GLYPH_3: nibble_o = 4'h3;
      GLYPH_4: nibble_o = 4'h4;
      GLYPH_5: nibble_o = 4'h5;
      GLYPH_6: nibble_o = 4'h6;
      GLYPH_7: nibble_o = 4'h7;
      GLYPH_8: nibble_o = 4'h8;
      GLYPH_9: nibble_o = 4'h9;
      GLYPH_A: nibble_o = 4'hA;
      GLYPH_B: nibble_o = 4'hB;
      GLYPH_C: nibble_o = 4'hC;
      GLYPH_D: nibble_o = 4'hD;
      GLYPH_E: nibble_o = 4'hE;
      GLYPH_F: nibble_o = 4'hF;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the 32-bit word shown on a multiplexed 8-digit seven-segment scan bus.
// Define SEG_SCAN_DECODER_DP_EN to also capture the decimal points on output dp.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYC     = 16,
  parameter int TIMEOUT_CYC    = 262144,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  which,
  input  logic [7:0]  seg,
  output logic [31:0] data,
  output logic        data_valid,
  output logic        glyph_err,
  output logic        timeout
`ifdef SEG_SCAN_DECODER_DP_EN
  ,
  output logic [7:0]  dp
`endif
);

  localparam int STAB_W = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(SETTLE_CYC);
  localparam logic [STAB_W-1:0] STAB_HIT = STAB_W'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_HIT  = TMO_W'(TIMEOUT_CYC - 1);

  logic [2:0]        which_q;
  logic [7:0]        seg_q;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              taken_q, taken_d;
  logic [31:0]       nib_buf_q, nib_buf_d;
  logic [7:0]        mask_q, mask_d;
  logic              err_acc_q, err_acc_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  state_e            state_q, state_d;
  logic [31:0]       data_q, data_d;
  logic              data_valid_q, data_valid_d;
  logic              glyph_err_q, glyph_err_d;
  logic              timeout_q, timeout_d;
`ifdef SEG_SCAN_DECODER_DP_EN
  logic [7:0]        dp_buf_q, dp_buf_d;
  logic [7:0]        dp_q, dp_d;
`endif

  logic              changed_s;
  logic              sample_s;
  logic              tmo_hit_s;
  logic [6:0]        pattern_s;
  logic [3:0]        nibble_s;
  logic              glyph_ok_s;
  logic [7:0]        sel_s;
  logic [4:0]        nib_idx_s;

  assign changed_s = ({which, seg} != {which_q, seg_q});
  assign sample_s  = !taken_q && (stab_cnt_q == STAB_HIT);
  assign tmo_hit_s = (tmo_cnt_q == TMO_HIT);
  assign pattern_s = SEG_ACTIVE_LOW ? ~seg_q[6:0] : seg_q[6:0];
  assign sel_s     = 8'b0000_0001 << which_q;
  assign nib_idx_s = {which_q, 2'b00};

  seg7_glyph_decode u_glyph (
    .pattern_i (pattern_s),
    .nibble_o  (nibble_s),
    .valid_o   (glyph_ok_s)
  );

  // Dwell tracking: one sample per stable dwell, re-armed only by a bus change
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    taken_d    = taken_q;
    if (changed_s) begin
      stab_cnt_d = '0;
      taken_d    = 1'b0;
    end else begin
      stab_cnt_d = (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + STAB_W'(1);
      taken_d    = taken_q | sample_s;
    end
  end

  // Frame assembly FSM with buffer, mask, timeout and output update
  always_comb begin
    state_d      = state_q;
    nib_buf_d    = nib_buf_q;
    mask_d       = mask_q;
    err_acc_d    = err_acc_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    glyph_err_d  = glyph_err_q;
    timeout_d    = 1'b0;
`ifdef SEG_SCAN_DECODER_DP_EN
    dp_buf_d     = dp_buf_q;
    dp_d         = dp_q;
`endif

    if (sample_s) begin
      nib_buf_d[nib_idx_s +: 4] = glyph_ok_s ? nibble_s : 4'h0;
`ifdef SEG_SCAN_DECODER_DP_EN
      dp_buf_d[which_q] = SEG_ACTIVE_LOW ? ~seg_q[7] : seg_q[7];
`endif
    end else begin
      nib_buf_d = nib_buf_q;
    end

    case (state_q)
      IDLE: begin
        if (sample_s) begin
          mask_d    = sel_s;
          err_acc_d = !glyph_ok_s;
          state_d   = COLLECT;
        end else begin
          mask_d    = 8'h00;
          err_acc_d = 1'b0;
        end
      end
      COLLECT: begin
        if (sample_s) begin
          mask_d    = mask_q | sel_s;
          err_acc_d = err_acc_q | !glyph_ok_s;
          if ((mask_q | sel_s) == 8'hFF) begin
            state_d = EMIT;
          end else begin
            state_d = COLLECT;
          end
        end else if (tmo_hit_s) begin
          mask_d    = 8'h00;
          err_acc_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = COLLECT;
        end
      end
      EMIT: begin
        data_d       = nib_buf_q;
        data_valid_d = 1'b1;
        glyph_err_d  = err_acc_q;
`ifdef SEG_SCAN_DECODER_DP_EN
        dp_d         = dp_buf_q;
`endif
        // A sample landing here opens the next frame rather than being dropped
        if (sample_s) begin
          mask_d    = sel_s;
          err_acc_d = !glyph_ok_s;
          state_d   = COLLECT;
        end else begin
          mask_d    = 8'h00;
          err_acc_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        mask_d    = 8'h00;
        err_acc_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    if (sample_s || (mask_q == 8'h00) || timeout_d) begin
      tmo_cnt_d = '0;
    end else if (tmo_hit_s) begin
      tmo_cnt_d = tmo_cnt_q;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  // Input capture and stability tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      which_q    <= 3'd0;
      seg_q      <= 8'h00;
      stab_cnt_q <= '0;
      taken_q    <= 1'b0;
    end else begin
      which_q    <= which;
      seg_q      <= seg;
      stab_cnt_q <= stab_cnt_d;
      taken_q    <= taken_d;
    end
  end

  // Frame state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      nib_buf_q    <= 32'h0000_0000;
      mask_q       <= 8'h00;
      err_acc_q    <= 1'b0;
      tmo_cnt_q    <= '0;
      data_q       <= 32'h0000_0000;
      data_valid_q <= 1'b0;
      glyph_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef SEG_SCAN_DECODER_DP_EN
      dp_buf_q     <= 8'h00;
      dp_q         <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      nib_buf_q    <= nib_buf_d;
      mask_q       <= mask_d;
      err_acc_q    <= err_acc_d;
      tmo_cnt_q    <= tmo_cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      glyph_err_q  <= glyph_err_d;
      timeout_q    <= timeout_d;
`ifdef SEG_SCAN_DECODER_DP_EN
      dp_buf_q     <= dp_buf_d;
      dp_q         <= dp_d;
`endif
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign glyph_err  = glyph_err_q;
  assign timeout    = timeout_q;
`ifdef SEG_SCAN_DECODER_DP_EN
  assign dp         = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: one active-high and one active-low instance
// share the scan bus; the second receives the inverted segment lines.
module tb_seg_scan_decoder;

  localparam int TMO = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  which = 3'd0;
  logic [7:0]  seg = 8'h3F;
  logic [7:0]  seg_n;
  logic [31:0] data, inv_data;
  logic        data_valid, glyph_err, timeout;
  logic        inv_valid, inv_glyph_err, inv_timeout;
`ifdef SEG_SCAN_DECODER_DP_EN
  logic [7:0]  dp, inv_dp;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_tmo = 0;
  int n_inv = 0;
  logic [31:0] vq[$];
  logic        eq[$];

  assign seg_n = ~seg;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE_CYC(16), .TIMEOUT_CYC(TMO), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .which(which), .seg(seg),
    .data(data), .data_valid(data_valid), .glyph_err(glyph_err), .timeout(timeout)
`ifdef SEG_SCAN_DECODER_DP_EN
    , .dp(dp)
`endif
  );

  seg_scan_decoder #(.SETTLE_CYC(16), .TIMEOUT_CYC(TMO), .SEG_ACTIVE_LOW(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .which(which), .seg(seg_n),
    .data(inv_data), .data_valid(inv_valid), .glyph_err(inv_glyph_err), .timeout(inv_timeout)
`ifdef SEG_SCAN_DECODER_DP_EN
    , .dp(inv_dp)
`endif
  );

  // Pulse monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (data_valid) begin
      vq.push_back(data);
      eq.push_back(glyph_err);
    end
    if (timeout) n_tmo++;
    if (inv_valid) n_inv++;
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic [31:0] w, input logic dpb, input logic blank);
    which = 3'(d);
    seg   = {dpb, blank ? 7'h00 : glyph(w[d*4 +: 4])};
  endtask

  task automatic scan_frame(input logic [31:0] w, input int dwell, input logic [7:0] dpm,
                            input logic [7:0] blank);
    for (int d = 0; d < 8; d++) begin
      drive(d, w, dpm[d], blank[d]);
      tick(dwell);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(1);
    n_cmp++; if (data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 00000000", data); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    n_cmp++; if (glyph_err !== 1'b0) begin n_bad++; $display("FAIL reset_gerr: got %b want 0", glyph_err); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
`ifdef SEG_SCAN_DECODER_DP_EN
    n_cmp++; if (dp !== 8'h00) begin n_bad++; $display("FAIL reset_dp: got %h want 00", dp); end
`endif
  endtask

  task automatic test_scan();
    vq.delete(); eq.delete();
    for (int d = 0; d < 7; d++) begin
      drive(d, 32'hFEDC_BA98, 1'b0, 1'b0);
      tick(64);
    end
    drive(7, 32'hFEDC_BA98, 1'b0, 1'b0);
    tick(17);
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL scan_early_valid: got %b want 0", data_valid); end
    tick(1);
    n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL scan_latency_valid: got %b want 1", data_valid); end
    n_cmp++; if (data !== 32'hFEDC_BA98) begin n_bad++; $display("FAIL scan_data: got %h want fedcba98", data); end
    n_cmp++; if (glyph_err !== 1'b0) begin n_bad++; $display("FAIL scan_gerr: got %b want 0", glyph_err); end
    tick(46);
    n_cmp++; if (vq.size() !== 1) begin n_bad++; $display("FAIL scan_pulses: got %0d want 1", vq.size()); end
  endtask

  task automatic test_changeover();
    logic [31:0] exp_w [4];
    exp_w = '{32'hFEDC_BA98, 32'hFEDC_BA98, 32'h7654_3210, 32'h7654_3210};
    vq.delete(); eq.delete();
    for (int f = 0; f < 4; f++) scan_frame(exp_w[f], 64, 8'h00, 8'h00);
    n_cmp++; if (vq.size() !== 4) begin n_bad++; $display("FAIL chg_pulses: got %0d want 4", vq.size()); end
    for (int f = 0; f < 4; f++) begin
      if (f < vq.size()) begin
        n_cmp++;
        if (vq[f] !== exp_w[f]) begin n_bad++; $display("FAIL chg_frame%0d: got %h want %h", f, vq[f], exp_w[f]); end
      end
    end
  endtask

  task automatic test_timeout();
    int t0;
    vq.delete(); eq.delete();
    t0 = n_tmo;
    for (int d = 0; d < 3; d++) begin
      drive(d, 32'h1111_1111, 1'b0, 1'b0);
      tick(20);
    end
    drive(3, 32'h1111_1111, 1'b0, 1'b0);
    tick(14);
    for (int i = 0; i < 225; i++) begin
      drive((i % 2 == 0) ? 4 : 3, 32'h1111_1111, 1'b0, 1'b0);
      tick(4);
      if (i == 100) begin
        n_cmp++; if (n_tmo !== t0) begin n_bad++; $display("FAIL tmo_early: got %0d want %0d", n_tmo, t0); end
      end
    end
    n_cmp++; if (n_tmo !== t0 + 1) begin n_bad++; $display("FAIL tmo_pulses: got %0d want %0d", n_tmo, t0 + 1); end
    n_cmp++; if (vq.size() !== 0) begin n_bad++; $display("FAIL tmo_valid: got %0d want 0", vq.size()); end
    n_cmp++; if (data !== 32'h7654_3210) begin n_bad++; $display("FAIL tmo_data_kept: got %h want 76543210", data); end
  endtask

  task automatic test_glyph_err();
    vq.delete(); eq.delete();
    scan_frame(32'h7654_3210, 64, 8'h00, 8'h20);
    scan_frame(32'h7654_3210, 64, 8'h00, 8'h00);
    n_cmp++; if (vq.size() !== 2) begin n_bad++; $display("FAIL gerr_pulses: got %0d want 2", vq.size()); end
    if (vq.size() >= 2) begin
      n_cmp++; if (vq[0] !== 32'h7604_3210) begin n_bad++; $display("FAIL gerr_data: got %h want 76043210", vq[0]); end
      n_cmp++; if (eq[0] !== 1'b1) begin n_bad++; $display("FAIL gerr_flag: got %b want 1", eq[0]); end
      n_cmp++; if (eq[1] !== 1'b0) begin n_bad++; $display("FAIL gerr_clean: got %b want 0", eq[1]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    vq.delete(); eq.delete();
    for (int d = 0; d < 4; d++) begin
      drive(d, 32'hFEDC_BA98, 1'b0, 1'b0);
      tick(20);
    end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    n_cmp++; if (data !== 32'h0) begin n_bad++; $display("FAIL rstmid_data_clr: got %h want 00000000", data); end
    scan_frame(32'h1357_9BDF, 64, 8'h00, 8'h00);
    n_cmp++; if (vq.size() !== 1) begin n_bad++; $display("FAIL rstmid_pulses: got %0d want 1", vq.size()); end
    n_cmp++; if (data !== 32'h1357_9BDF) begin n_bad++; $display("FAIL rstmid_data: got %h want 13579bdf", data); end
  endtask

  task automatic test_active_low();
    int i0;
    i0 = n_inv;
    scan_frame(32'h0123_4567, 32, 8'h80, 8'h00);
    n_cmp++; if (inv_data !== 32'h0123_4567) begin n_bad++; $display("FAIL actlow_data: got %h want 01234567", inv_data); end
    n_cmp++; if (n_inv !== i0 + 1) begin n_bad++; $display("FAIL actlow_pulses: got %0d want %0d", n_inv, i0 + 1); end
    n_cmp++; if (data !== 32'h0123_4567) begin n_bad++; $display("FAIL dp_frame_data: got %h want 01234567", data); end
`ifdef SEG_SCAN_DECODER_DP_EN
    n_cmp++; if (dp !== 8'h80) begin n_bad++; $display("FAIL dp_bits: got %h want 80", dp); end
`endif
  endtask

  initial begin
    test_reset();
    test_scan();
    test_changeover();
    test_timeout();
    test_glyph_err();
    test_reset_mid_frame();
    test_active_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receives the multiplexed 8-digit seven-segment scan bus (which/seg) produced by the display scanner.
- Reconstructs the 32-bit hex word that is being shown, and flags undecodable glyphs.
- Used as a loopback monitor in board self-test and as a bus checker in display benches.
- Sits on the same which/seg nets that drive the LEDs.

Parameters:
- SETTLE_CYC, 16: cycles which/seg must hold unchanged before a digit is sampled.
- TIMEOUT_CYC, 262144: cycles without a new digit before a partial frame is discarded.
- SEG_ACTIVE_LOW, 0: 1 means the seg input is inverted before decoding.

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- which  in  3  index of the digit currently driven; 0 means data[3:0], 7 means data[31:28].
- seg  in  8  segment lines: seg[7]=dp, seg[6:0]={g,f,e,d,c,b,a}.
- data  out  32  last complete reconstructed word.
- data_valid  out  1  one-cycle pulse when data updates.
- glyph_err  out  1  sticky per frame: at least one digit in the frame shown on data was undecodable.
- timeout  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Input registers: which and seg are registered once (which_q, seg_q). All logic operates on these registered values.
- Stability counter stab_cnt:
  - Clears to 0 when {which, seg} differs from {which_q, seg_q}.
  - Otherwise increments, saturating at SETTLE_CYC.
- Digit sample:
  - Occurs exactly once per dwell, in the cycle stab_cnt reaches SETTLE_CYC-1.
  - A "taken" flag blocks re-sampling until {which, seg} next changes.
- Glyph decode (active-high after optional inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Any other pattern is invalid. dp is ignored for decoding.
- On a sample:
  - buf[which*4 +: 4] is loaded with the decoded nibble. An invalid glyph loads 0 and sets err_acc.
  - mask[which] is set.
  - Re-sampling a digit already in mask overwrites its nibble; the frame does not advance.
- Frame complete: in the cycle after mask becomes 8'hFF:
  - data is loaded with buf (including the nibble sampled in the previous cycle).
  - data_valid=1 and glyph_err=err_acc.
  - mask and err_acc clear.
  - Total latency is 2 cycles from the 8th sample.
- Timeout counter:
  - Resets on every sample and whenever mask==0.
  - Reaching TIMEOUT_CYC-1 with mask!=0 clears mask and err_acc, pulses timeout for 1 cycle, and leaves data unchanged.
- Simultaneous events: a sample in the same cycle as a timeout means the sample wins and the timeout is suppressed.
- State machine:
  - IDLE (mask==0) -> COLLECT on the first sample.
  - COLLECT -> EMIT when mask becomes full.
  - COLLECT -> IDLE on timeout.
  - EMIT -> IDLE after one cycle.
  - Samples arriving during EMIT are not lost: they start the next frame.
- Reset values: data=0, data_valid=0, glyph_err=0, timeout=0, mask=0, counters=0, state=IDLE.
- Reset mid-frame discards the partial buffer with no pulse.

Optional Feature:
- Macro: SEG_SCAN_DECODER_DP_EN.
- Defined:
  - Adds output port dp out 8: the dp bits, indexed by digit.
  - dp is captured alongside nibbles and updated together with data. Reset value 0.
- Undefined: the port and its registers are absent, and dp is fully ignored.

Decomposition:
- Package seg_pkg holds:
  - the 16 glyph localparams;
  - NUM_DIGITS=8;
  - a state enum typedef (IDLE, COLLECT, EMIT).
- One sub-module, seg7_glyph_decode (combinational): 7-bit pattern in, 4-bit nibble plus valid bit out. It is instantiated once.

Test Plan:
- Scan data 32'hFEDC_BA98, dwell 64 cycles per digit, which 0..7 -> one data_valid pulse, data=32'hFEDC_BA98, glyph_err=0.
- Change the scanned value to 32'h7654_3210 mid-run -> the first fully-new frame yields data=32'h7654_3210; no spurious pulse during the changeover.
- Dwell of only SETTLE_CYC-2 cycles on digit 3 -> digit 3 is never sampled, no data_valid, then a timeout pulse after TIMEOUT_CYC.
- Digit 5 shows pattern 7'h00 -> data[23:20]=0 and glyph_err=1 for that frame; the next clean frame gives glyph_err=0.
- Assert rst after 4 digits are captured, then scan a full frame -> exactly one data_valid, and data holds only the post-reset values.
- SEG_ACTIVE_LOW=1 with inverted patterns for 32'h0123_4567 -> data=32'h0123_4567. With the macro defined and dp set on digit 7 -> dp=8'h80.
